// File: rtl/fruit_spawner.sv
// fruit_spawner: paces fruit/bomb launches and offers one randomized spawn descriptor at a time
module fruit_spawner #(
  parameter int MIN_GAP     = 20,
  parameter int X_MIN       = 64,
  parameter int VY_BASE     = 12,
  parameter int BOMB_THRESH = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rand_word,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       spawn_ready,
  output logic       spawn_valid,
  output logic [9:0] spawn_x,
  output logic [3:0] spawn_vx,
  output logic [4:0] spawn_vy,
  output logic [1:0] spawn_type,
  output logic       spawn_bomb,
  output logic [7:0] spawn_count
);
  typedef enum logic [2:0] {IDLE, WAIT, S0, S1, S2, OFFER} state_t;
  state_t state, state_n;
  logic [8:0] gap_cnt, gap_n;
  logic       valid_n, bomb_n;
  logic [9:0] x_n;
  logic [3:0] vx_n;
  logic [4:0] vy_n;
  logic [1:0] type_n;
  logic [7:0] count_n;
  logic       accept;
  assign accept = state == OFFER && enable && spawn_ready;
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      spawn_valid <= 1'b0;
      spawn_x     <= '0;
      spawn_vx    <= '0;
      spawn_vy    <= '0;
      spawn_type  <= '0;
      spawn_bomb  <= 1'b0;
      spawn_count <= '0;
    end else begin
      state       <= state_n;
      gap_cnt     <= gap_n;
      spawn_valid <= valid_n;
      spawn_x     <= x_n;
      spawn_vx    <= vx_n;
      spawn_vy    <= vy_n;
      spawn_type  <= type_n;
      spawn_bomb  <= bomb_n;
      spawn_count <= count_n;
    end
  end
  // next state: dropping enable returns to IDLE ahead of any other transition
  always_comb begin
    state_n = state;
    if (!enable) state_n = IDLE;
    else case (state)
      IDLE:    state_n = WAIT;
      WAIT:    state_n = frame_tick && gap_cnt <= 9'd1 ? S0 : WAIT;
      S0:      state_n = S1;
      S1:      state_n = S2;
      S2:      state_n = OFFER;
      OFFER:   state_n = spawn_ready ? WAIT : OFFER;
      default: state_n = IDLE;
    endcase
  end
  // next output values: each field latches only on its build step, so an offer holds steady
  always_comb begin
    gap_n   = state_n == WAIT && state != WAIT ? 9'(MIN_GAP) + 9'(rand_word) :
              state == WAIT && state_n == WAIT && frame_tick ? gap_cnt - 9'd1 : gap_cnt;
    valid_n = state_n == OFFER;
    x_n     = state == S0 && state_n == S1 ? 10'(X_MIN) + {1'b0, rand_word, 4'b0000} : spawn_x;
    vx_n    = state == S1 && state_n == S2 ? {1'b0, rand_word[2:0]} - 4'd4 : spawn_vx;
    type_n  = state == S1 && state_n == S2 ? rand_word[4:3] : spawn_type;
    vy_n    = state == S2 && state_n == OFFER ? 5'(VY_BASE) + {1'b0, rand_word[3:0]} : spawn_vy;
    bomb_n  = state == S2 && state_n == OFFER ? int'(rand_word) >= BOMB_THRESH : spawn_bomb;
    count_n = accept ? spawn_count + 8'd1 : spawn_count;
  end
endmodule

// File: tb/tb_fruit_spawner.sv
// tb_fruit_spawner: vector table, corner sequences and randomized model comparison for fruit_spawner
module tb_fruit_spawner;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, en, ft, rdy, v, bomb;
  logic [4:0] rw, vy;
  logic [9:0] x;
  logic [3:0] vx;
  logic [1:0] ty;
  logic [7:0] cnt;
  logic rst1, en1, ft1, rdy1, v1, bomb1;
  logic [4:0] rw1, vy1;
  logic [9:0] x1;
  logic [3:0] vx1;
  logic [1:0] ty1;
  logic [7:0] cnt1;
  int n_chk = 0, n_fail = 0;
  fruit_spawner u0 (.clk(clk), .rst(rst), .rand_word(rw), .frame_tick(ft), .enable(en), .spawn_ready(rdy),
    .spawn_valid(v), .spawn_x(x), .spawn_vx(vx), .spawn_vy(vy), .spawn_type(ty), .spawn_bomb(bomb), .spawn_count(cnt));
  fruit_spawner #(.MIN_GAP(0)) u1 (.clk(clk), .rst(rst1), .rand_word(rw1), .frame_tick(ft1), .enable(en1), .spawn_ready(rdy1),
    .spawn_valid(v1), .spawn_x(x1), .spawn_vx(vx1), .spawn_vy(vy1), .spawn_type(ty1), .spawn_bomb(bomb1), .spawn_count(cnt1));
  typedef struct { int r; int x; int vx; int vy; int ty; int bomb; } vec_t;
  vec_t tbl[6];
  int m_ph, m_gap, m_x, m_vx, m_vy, m_ty, m_b, m_c;
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1; en = 0; ft = 0; rdy = 0; rw = 0;
    tick;
    rst = 0;
  endtask
  task automatic wait_valid(output int k);
    k = 0;
    while (!v && k < 400) begin
      tick;
      k++;
    end
  endtask
  task automatic check_fields(input string tag, input vec_t t);
    check({tag, " x"}, int'(x), t.x);
    check({tag, " vx"}, int'($signed(vx)), t.vx);
    check({tag, " vy"}, int'(vy), t.vy);
    check({tag, " type"}, int'(ty), t.ty);
    check({tag, " bomb"}, int'(bomb), t.bomb);
  endtask
  task automatic check_zero(input string tag);
    check({tag, " valid"}, int'(v), 0);
    check({tag, " x"}, int'(x), 0);
    check({tag, " vx"}, int'(vx), 0);
    check({tag, " vy"}, int'(vy), 0);
    check({tag, " type"}, int'(ty), 0);
    check({tag, " bomb"}, int'(bomb), 0);
    check({tag, " count"}, int'(cnt), 0);
  endtask
  // reference behaviour: phase 0 idle, 1 waiting, 2..4 building x / vx,type / vy,bomb, 5 offering
  task automatic model_step;
    int r;
    r = int'(rw);
    if (rst) begin
      m_ph = 0; m_gap = 0; m_x = 0; m_vx = 0; m_vy = 0; m_ty = 0; m_b = 0; m_c = 0;
    end else if (!en) m_ph = 0;
    else if (m_ph == 0) begin
      m_gap = 20 + r; m_ph = 1;
    end else if (m_ph == 1) begin
      if (ft && m_gap <= 1) m_ph = 2;
      else if (ft) m_gap = m_gap - 1;
    end else if (m_ph == 2) begin
      m_x = 64 + r * 16; m_ph = 3;
    end else if (m_ph == 3) begin
      m_vx = (r % 8) - 4; m_ty = r / 8; m_ph = 4;
    end else if (m_ph == 4) begin
      m_vy = 12 + r % 16; m_b = r >= 28 ? 1 : 0; m_ph = 5;
    end else if (rdy) begin
      m_c = (m_c + 1) % 256; m_gap = 20 + r; m_ph = 1;
    end
  endtask
  initial begin
    int k, acc;
    vec_t a;
    tbl[0] = '{3, 112, -1, 15, 0, 0};
    tbl[1] = '{31, 560, 3, 27, 3, 1};
    tbl[2] = '{0, 64, -4, 12, 0, 0};
    tbl[3] = '{27, 496, -1, 23, 3, 0};
    tbl[4] = '{28, 512, 0, 24, 3, 1};
    tbl[5] = '{16, 320, -4, 12, 2, 0};
    rst1 = 1; en1 = 0; ft1 = 0; rdy1 = 0; rw1 = 0;
    for (int i = 0; i < 6; i++) begin
      do_reset;
      check_zero($sformatf("reset%0d", i));
      rw = 5'(tbl[i].r); en = 1; ft = 1; rdy = 0;
      wait_valid(k);
      check($sformatf("latency r=%0d", tbl[i].r), k, 24 + tbl[i].r);
      check_fields($sformatf("vec r=%0d", tbl[i].r), tbl[i]);
      for (int j = 0; j < 10; j++) begin
        rw = 5'($urandom);
        tick;
        check("hold valid", int'(v), 1);
      end
      check_fields($sformatf("held r=%0d", tbl[i].r), tbl[i]);
      rdy = 1;
      tick;
      check("accept valid", int'(v), 0);
      check("accept count", int'(cnt), 1);
    end
    do_reset;
    rw = 3; en = 1; rdy = 1;
    tick;
    for (int i = 0; i < 23; i++) begin
      ft = 1;
      tick;
      ft = 0;
      if (i < 22) tick;
    end
    tick;
    tick;
    check("s0+2 valid", int'(v), 0);
    tick;
    check("s0+3 valid", int'(v), 1);
    check_fields("pulse", tbl[0]);
    tick;
    check("pulse drop", int'(v), 0);
    check("pulse count", int'(cnt), 1);
    do_reset;
    rw = 5; en = 1; ft = 1;
    repeat (5) tick;
    en = 0;
    tick;
    check("wait drop valid", int'(v), 0);
    en = 1;
    wait_valid(k);
    check("restart latency", k, 29);
    en = 0; rdy = 1;
    tick;
    check("offer drop valid", int'(v), 0);
    check("offer drop count", int'(cnt), 0);
    en = 1;
    wait_valid(k);
    check("reenable latency", k, 29);
    do_reset;
    rw = 31; en = 1; ft = 1; rdy = 1;
    wait_valid(k);
    tick;
    check("pre-rst count", int'(cnt), 1);
    repeat (52) tick;
    check("in S1 valid", int'(v), 0);
    rst = 1;
    tick;
    rst = 0;
    check_zero("rst in S1");
    rw = 3;
    wait_valid(k);
    check("post-rst latency", k, 27);
    rst = 1;
    tick;
    rst = 0;
    check_zero("rst in OFFER");
    rst1 = 0; en1 = 1; rdy1 = 1;
    repeat (3) tick;
    check("gap0 no tick", int'(v1), 0);
    ft1 = 1;
    tick;
    ft1 = 0;
    tick;
    tick;
    check("gap0 s0+2", int'(v1), 0);
    tick;
    check("gap0 s0+3", int'(v1), 1);
    check("gap0 x", int'(x1), 64);
    tick;
    check("gap0 count", int'(cnt1), 1);
    ft1 = 1; acc = 1; k = 0;
    while (acc < 256 && k < 5000) begin
      if (v1) acc++;
      if (acc == 255 && v1) check("count 255", int'(cnt1), 254);
      tick;
      k++;
    end
    check("accepted 256", acc, 256);
    check("count wrap", int'(cnt1), 0);
    rst = 1; en = 0; ft = 0; rdy = 0; rw = 0;
    for (int i = 0; i < 4000; i++) begin
      model_step;
      tick;
      check("rnd valid", int'(v), m_ph == 5 ? 1 : 0);
      a = '{0, m_x, m_vx, m_vy, m_ty, m_b};
      check_fields("rnd", a);
      check("rnd count", int'(cnt), m_c);
      rst = $urandom_range(0, 499) == 0;
      en = $urandom_range(0, 399) != 0;
      ft = $urandom_range(0, 1) == 1;
      rdy = $urandom_range(0, 2) == 0;
      rw = 5'($urandom);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
